sm83_irq_ctrl: RTL and testbench



---
 rtl/sm83_irq_ctrl_pkg.sv | 21 ++
 rtl/sm83_irq_prio_enc.sv | 24 ++
 rtl/sm83_irq_ctrl.sv | 131 +++++++++++++
 tb/tb_sm83_irq_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sm83_irq_ctrl_pkg.sv
// Shared SM83 interrupt-controller types, defaults and the vector helper.
package sm83_irq_ctrl_pkg;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_REQ  = 1'b1
  } irq_state_t;

  localparam logic [15:0] IRQ_VEC_BASE_DEFAULT   = 16'h0040;
  localparam int unsigned IRQ_VEC_STRIDE_DEFAULT = 8;
  localparam int unsigned IRQ_MAX                = 8;
  localparam int unsigned IRQ_IDX_W              = 3;

  // 16-bit wrapping vector address for source idx.
  function automatic logic [15:0] irq_vector(input logic [15:0] base,
                                             input int unsigned stride,
                                             input logic [IRQ_IDX_W-1:0] idx);
    return base + 16'(stride * 32'(idx));
  endfunction

endpackage

// File: rtl/sm83_irq_prio_enc.sv
// Lowest-index-first priority encoder: bit 0 has the highest priority.
module sm83_irq_prio_enc
  import sm83_irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 5
) (
  input  logic [NUM_IRQ-1:0]   req_i,
  output logic                 valid_o,
  output logic [IRQ_IDX_W-1:0] idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    // Scan high to low so the lowest set index is the last assignment.
    for (int unsigned i = NUM_IRQ; i > 0; i--) begin
      if (req_i[i-1]) begin
        valid_o = 1'b1;
        idx_o   = IRQ_IDX_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/sm83_irq_ctrl.sv
// SM83 interrupt controller: IE/IF registers, IME with EI delay, req/ack dispatch.
// Define SM83_IRQ_EDGE_EN for rising-edge request capture (default: level).
module sm83_irq_ctrl
  import sm83_irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 5,
  parameter logic [15:0] VEC_BASE   = IRQ_VEC_BASE_DEFAULT,
  parameter int unsigned VEC_STRIDE = IRQ_VEC_STRIDE_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_req_i,
  input  logic               ie_wr_i,
  input  logic               if_wr_i,
  input  logic [7:0]         wdata_i,
  output logic [7:0]         ie_o,
  output logic [7:0]         if_o,
  input  logic               ctl_ei_i,
  input  logic               ctl_di_i,
  input  logic               ctl_reti_i,
  input  logic               instr_done_i,
  output logic               dispatch_req_o,
  input  logic               dispatch_ack_i,
  output logic [15:0]        vector_o,
  output logic               ime_o,
  output logic               wake_o
);

  irq_state_t           state_q, state_d;
  logic [NUM_IRQ-1:0]   ie_q, ie_d;
  logic [NUM_IRQ-1:0]   if_q, if_d;
  logic                 ime_q, ime_d;
  logic                 ei_armed_q, ei_armed_d;
  logic [NUM_IRQ-1:0]   pending, set_mask, clr_mask;
  logic                 pend_valid, ack_take;
  logic [IRQ_IDX_W-1:0] sel;
  logic                 unused_wdata;

  assign unused_wdata = ^wdata_i;
  assign pending      = ie_q & if_q;
  assign ack_take     = (state_q == IRQ_REQ) && dispatch_ack_i;

  sm83_irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req_i   (pending),
    .valid_o (pend_valid),
    .idx_o   (sel)
  );

`ifdef SM83_IRQ_EDGE_EN
  logic [NUM_IRQ-1:0] irq_prev_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_prev_q <= '0;
    else        irq_prev_q <= irq_req_i;
  end
  assign set_mask = irq_req_i & ~irq_prev_q;
`else
  assign set_mask = irq_req_i;
`endif

  always_comb begin
    clr_mask = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (ack_take && pend_valid && (32'(sel) == i)) clr_mask[i] = 1'b1;
    end
    ie_d = ie_wr_i ? wdata_i[NUM_IRQ-1:0] : ie_q;
    if_d = if_wr_i ? wdata_i[NUM_IRQ-1:0] : if_q;
    // New requests are OR-ed last so they beat both writes and dispatch clears.
    if_d = (if_d & ~clr_mask) | set_mask;
  end

  always_comb begin
    ime_d      = ime_q;
    ei_armed_d = ei_armed_q;
    if (instr_done_i && ei_armed_q) begin
      ime_d      = 1'b1;
      ei_armed_d = 1'b0;
    end
    if (ctl_ei_i && !ime_q) ei_armed_d = 1'b1;
    if (ctl_reti_i)         ime_d      = 1'b1;
    if (ctl_di_i) begin
      ime_d      = 1'b0;
      ei_armed_d = 1'b0;
    end
    if (ack_take) ime_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IRQ_IDLE: if (instr_done_i && ime_q && pend_valid) state_d = IRQ_REQ;
      IRQ_REQ:  if (dispatch_ack_i) state_d = IRQ_IDLE;
      default:  state_d = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IRQ_IDLE;
      ie_q       <= '0;
      if_q       <= '0;
      ime_q      <= 1'b0;
      ei_armed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ie_q       <= ie_d;
      if_q       <= if_d;
      ime_q      <= ime_d;
      ei_armed_q <= ei_armed_d;
    end
  end

  always_comb begin
    ie_o = '0;
    if_o = '1;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      ie_o[i] = ie_q[i];
      if_o[i] = if_q[i];
    end
  end

  always_comb begin
    if (pend_valid)                vector_o = irq_vector(VEC_BASE, VEC_STRIDE, sel);
    else if (state_q == IRQ_REQ)   vector_o = 16'h0000;
    else                           vector_o = VEC_BASE;
  end

  assign dispatch_req_o = (state_q == IRQ_REQ);
  assign ime_o          = ime_q;
  assign wake_o         = |pending;

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Directed self-checking bench for sm83_irq_ctrl (NUM_IRQ=5, default vectors).
module tb_sm83_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  irq_req_i = '0;
  logic        ie_wr_i = 1'b0;
  logic        if_wr_i = 1'b0;
  logic [7:0]  wdata_i = '0;
  logic [7:0]  ie_o, if_o;
  logic        ctl_ei_i = 1'b0, ctl_di_i = 1'b0, ctl_reti_i = 1'b0;
  logic        instr_done_i = 1'b0;
  logic        dispatch_req_o;
  logic        dispatch_ack_i = 1'b0;
  logic [15:0] vector_o;
  logic        ime_o, wake_o;

  int checks = 0;
  int errors = 0;

  sm83_irq_ctrl #(.NUM_IRQ(5), .VEC_BASE(16'h0040), .VEC_STRIDE(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .irq_req_i      (irq_req_i),
    .ie_wr_i        (ie_wr_i),
    .if_wr_i        (if_wr_i),
    .wdata_i        (wdata_i),
    .ie_o           (ie_o),
    .if_o           (if_o),
    .ctl_ei_i       (ctl_ei_i),
    .ctl_di_i       (ctl_di_i),
    .ctl_reti_i     (ctl_reti_i),
    .instr_done_i   (instr_done_i),
    .dispatch_req_o (dispatch_req_o),
    .dispatch_ack_i (dispatch_ack_i),
    .vector_o       (vector_o),
    .ime_o          (ime_o),
    .wake_o         (wake_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ie(input logic [7:0] v);
    ie_wr_i = 1'b1; wdata_i = v; cyc(); ie_wr_i = 1'b0;
  endtask

  task automatic write_if(input logic [7:0] v);
    if_wr_i = 1'b1; wdata_i = v; cyc(); if_wr_i = 1'b0;
  endtask

  task automatic pulse_irq(input logic [4:0] v);
    irq_req_i = v; cyc(); irq_req_i = '0;
  endtask

  task automatic pulse_reti();
    ctl_reti_i = 1'b1; cyc(); ctl_reti_i = 1'b0;
  endtask

  task automatic pulse_ei();
    ctl_ei_i = 1'b1; cyc(); ctl_ei_i = 1'b0;
  endtask

  task automatic pulse_di();
    ctl_di_i = 1'b1; cyc(); ctl_di_i = 1'b0;
  endtask

  task automatic boundary();
    instr_done_i = 1'b1; cyc(); instr_done_i = 1'b0;
  endtask

  task automatic ack();
    dispatch_ack_i = 1'b1; cyc(); dispatch_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(); cyc();
    checks++; if (ie_o !== 8'h00) begin errors++; $display("FAIL reset_ie: got %h expected 00", ie_o); end
    checks++; if (if_o !== 8'hE0) begin errors++; $display("FAIL reset_if: got %h expected e0", if_o); end
    checks++; if (ime_o !== 1'b0) begin errors++; $display("FAIL reset_ime: got %b expected 0", ime_o); end
    checks++; if (dispatch_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", dispatch_req_o); end
    checks++; if (vector_o !== 16'h0040) begin errors++; $display("FAIL reset_vector: got %h expected 0040", vector_o); end
    checks++; if (wake_o !== 1'b0) begin errors++; $display("FAIL reset_wake: got %b expected 0", wake_o); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_basic_dispatch();
    write_ie(8'h1F);
    checks++; if (ie_o !== 8'h1F) begin errors++; $display("FAIL basic_ie: got %h expected 1f", ie_o); end
    pulse_reti();
    checks++; if (ime_o !== 1'b1) begin errors++; $display("FAIL basic_reti_ime: got %b expected 1", ime_o); end
    pulse_irq(5'b00100);
    checks++; if (if_o !== 8'hE4) begin errors++; $display("FAIL basic_if_set: got %h expected e4", if_o); end
    checks++; if (dispatch_req_o !== 1'b0) begin errors++; $display("FAIL basic_req_early: got %b expected 0", dispatch_req_o); end
    boundary();
    checks++; if (dispatch_req_o !== 1'b1) begin errors++; $display("FAIL basic_req: got %b expected 1", dispatch_req_o); end
    checks++; if (vector_o !== 16'h0050) begin errors++; $display("FAIL basic_vector: got %h expected 0050", vector_o); end
    cyc();
    checks++; if (dispatch_req_o !== 1'b1) begin errors++; $display("FAIL basic_req_hold: got %b expected 1", dispatch_req_o); end
    ack();
    checks++; if (dispatch_req_o !== 1'b0) begin errors++; $display("FAIL basic_req_after_ack: got %b expected 0", dispatch_req_o); end
    checks++; if (if_o !== 8'hE0) begin errors++; $display("FAIL basic_if_clear: got %h expected e0", if_o); end
    checks++; if (ime_o !== 1'b0) begin errors++; $display("FAIL basic_ime_clear: got %b expected 0", ime_o); end
  endtask

  task automatic test_priority();
    write_if(8'h1F);
    write_ie(8'h14);
    pulse_reti();
    boundary();
    checks++; if (vector_o !== 16'h0050) begin errors++; $display("FAIL prio_first_vector: got %h expected 0050", vector_o); end
    ack();
    checks++; if (if_o !== 8'hFB) begin errors++; $display("FAIL prio_if_after_first: got %h expected fb", if_o); end
    boundary();
    checks++; if (dispatch_req_o !== 1'b0) begin errors++; $display("FAIL prio_no_req_ime0: got %b expected 0", dispatch_req_o); end
    pulse_reti();
    boundary();
    checks++; if (dispatch_req_o !== 1'b1) begin errors++; $display("FAIL prio_second_req: got %b expected 1", dispatch_req_o); end
    checks++; if (vector_o !== 16'h0060) begin errors++; $display("FAIL prio_second_vector: got %h expected 0060", vector_o); end
    ack();
    checks++; if (if_o !== 8'hEB) begin errors++; $display("FAIL prio_if_after_second: got %h expected eb", if_o); end
    write_if(8'h00);
    write_ie(8'h00);
  endtask

  task automatic test_ei_delay();
    write_ie(8'h01);
    pulse_irq(5'b00001);
    pulse_ei();
    checks++; if (ime_o !== 1'b0) begin errors++; $display("FAIL ei_ime_before_boundary: got %b expected 0", ime_o); end
    boundary();
    checks++; if (ime_o !== 1'b1) begin errors++; $display("FAIL ei_ime_armed: got %b expected 1", ime_o); end
    checks++; if (dispatch_req_o !== 1'b0) begin errors++; $display("FAIL ei_arming_no_req: got %b expected 0", dispatch_req_o); end
    boundary();
    checks++; if (dispatch_req_o !== 1'b1) begin errors++; $display("FAIL ei_second_boundary_req: got %b expected 1", dispatch_req_o); end
    checks++; if (vector_o !== 16'h0040) begin errors++; $display("FAIL ei_vector: got %h expected 0040", vector_o); end
    ack();
    pulse_irq(5'b00001);
    pulse_ei();
    pulse_di();
    boundary();
    checks++; if (ime_o !== 1'b0) begin errors++; $display("FAIL ei_di_ime: got %b expected 0", ime_o); end
    boundary();
    checks++; if (dispatch_req_o !== 1'b0) begin errors++; $display("FAIL ei_di_no_req: got %b expected 0", dispatch_req_o); end
    write_if(8'h00);
  endtask

  task automatic test_ack_empty();
    write_ie(8'h02);
    pulse_irq(5'b00010);
    pulse_reti();
    boundary();
    checks++; if (dispatch_req_o !== 1'b1) begin errors++; $display("FAIL empty_req: got %b expected 1", dispatch_req_o); end
    write_if(8'h00);
    checks++; if (vector_o !== 16'h0000) begin errors++; $display("FAIL empty_vector: got %h expected 0000", vector_o); end
    pulse_di();
    checks++; if (dispatch_req_o !== 1'b1) begin errors++; $display("FAIL di_in_req_holds: got %b expected 1", dispatch_req_o); end
    ack();
    checks++; if (dispatch_req_o !== 1'b0) begin errors++; $display("FAIL empty_req_after_ack: got %b expected 0", dispatch_req_o); end
    checks++; if (if_o !== 8'hE0) begin errors++; $display("FAIL empty_if: got %h expected e0", if_o); end
    checks++; if (ime_o !== 1'b0) begin errors++; $display("FAIL empty_ime: got %b expected 0", ime_o); end
  endtask

  task automatic test_wake();
    write_ie(8'h01);
    checks++; if (wake_o !== 1'b0) begin errors++; $display("FAIL wake_idle: got %b expected 0", wake_o); end
    pulse_irq(5'b00001);
    checks++; if (wake_o !== 1'b1) begin errors++; $display("FAIL wake_set: got %b expected 1", wake_o); end
    checks++; if (if_o !== 8'hE1) begin errors++; $display("FAIL wake_if: got %h expected e1", if_o); end
    boundary();
    checks++; if (dispatch_req_o !== 1'b0) begin errors++; $display("FAIL wake_no_req: got %b expected 0", dispatch_req_o); end
    write_if(8'h00);
    write_ie(8'h00);
  endtask

  task automatic test_held_line();
    logic [7:0] exp_if;
`ifdef SM83_IRQ_EDGE_EN
    exp_if = 8'hE0;
`else
    exp_if = 8'hE8;
`endif
    irq_req_i = 5'b01000;
    for (int i = 0; i < 4; i++) cyc();
    write_if(8'h00);
    for (int i = 0; i < 5; i++) cyc();
    irq_req_i = '0;
    cyc();
    checks++; if (if_o !== exp_if) begin errors++; $display("FAIL held_line_if: got %h expected %h", if_o, exp_if); end
    write_if(8'h00);
  endtask

  task automatic test_async_reset();
    write_ie(8'h01);
    pulse_irq(5'b00001);
    pulse_reti();
    boundary();
    checks++; if (dispatch_req_o !== 1'b1) begin errors++; $display("FAIL areset_pre_req: got %b expected 1", dispatch_req_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dispatch_req_o !== 1'b0) begin errors++; $display("FAIL areset_req_drop: got %b expected 0", dispatch_req_o); end
    checks++; if (ie_o !== 8'h00) begin errors++; $display("FAIL areset_ie: got %h expected 00", ie_o); end
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    test_reset();
    test_basic_dispatch();
    test_priority();
    test_ei_delay();
    test_ack_empty();
    test_wake();
    test_held_line();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
